// File: rtl/c_crc_accum_if.sv
// Beat and result channels of the word-serial CRC accumulator.
// The slave modport is the accumulator; the master modport is the producer/consumer side.
interface c_crc_accum_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic              in_eof;
  logic [0:DATA_W-1] in_data;
  logic              crc_valid;
  logic              crc_ready;
  logic [0:CRC_W-1]  crc_out;

  modport master (
    output in_valid, in_sof, in_eof, in_data, crc_ready,
    input  in_ready, crc_valid, crc_out
  );

  modport slave (
    input  in_valid, in_sof, in_eof, in_data, crc_ready,
    output in_ready, crc_valid, crc_out
  );
endinterface

// File: rtl/c_crc_accum.sv
// Word-serial, non-reflected MSB-first CRC accumulator. One word per beat is folded in
// through two GF(2) matrix products (state transition and data input) and the result is held for a consumer.
module c_mat_mult #(
  parameter int                   rows   = 16,
  parameter int                   cols   = 16,
  parameter logic [rows*cols-1:0] matrix = '0
) (
  input  logic [cols-1:0] vec_i,
  output logic [rows-1:0] prod_o
);
  always_comb begin
    prod_o = '0;
    for (int r = 0; r < rows; r++) begin
      prod_o[r] = ^(matrix[r*cols +: cols] & vec_i);
    end
  end
endmodule

module c_crc_accum #(
  parameter int                   data_width = 8,
  parameter int                   crc_width  = 16,
  parameter logic [crc_width-1:0] poly       = 16'h1021,
  parameter logic [crc_width-1:0] init_value = 16'hFFFF,
  parameter logic [crc_width-1:0] final_xor  = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  c_crc_accum_if.slave    bus,
  output logic            stray_beat_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Column k of A is unit vector x^k pushed through data_width zero-data serial steps.
  function automatic logic [crc_width*crc_width-1:0] buildA();
    logic [crc_width*crc_width-1:0] m;
    logic [crc_width-1:0]           c;
    logic                           fb;
    m = '0;
    for (int k = 0; k < crc_width; k++) begin
      c    = '0;
      c[k] = 1'b1;
      for (int s = 0; s < data_width; s++) begin
        fb = c[crc_width-1];
        c  = {c[crc_width-2:0], 1'b0} ^ (fb ? poly : '0);
      end
      for (int r = 0; r < crc_width; r++) m[r*crc_width+k] = c[r];
    end
    return m;
  endfunction

  // Data word is seen as an integer whose MSB (in_data[0]) enters at serial step 0.
  function automatic logic [crc_width*data_width-1:0] buildB();
    logic [crc_width*data_width-1:0] m;
    logic [crc_width-1:0]            c;
    logic                            fb;
    m = '0;
    for (int i = 0; i < data_width; i++) begin
      c = '0;
      for (int s = 0; s < data_width; s++) begin
        fb = c[crc_width-1] ^ (s == data_width - 1 - i);
        c  = {c[crc_width-2:0], 1'b0} ^ (fb ? poly : '0);
      end
      for (int r = 0; r < crc_width; r++) m[r*data_width+i] = c[r];
    end
    return m;
  endfunction

  localparam logic [crc_width*crc_width-1:0]  A_MAT = buildA();
  localparam logic [crc_width*data_width-1:0] B_MAT = buildB();

  logic [1:0]            state_q, state_d;
  logic [crc_width-1:0]  crc_q, crc_d;
  logic [crc_width-1:0]  out_q, out_d;
  logic                  ready_q, valid_q, stray_q, stray_d;
  logic [crc_width-1:0]  baseCrc, aProd, bProd, nextCrc;
  logic [data_width-1:0] dVec;
  logic                  accept;

  assign dVec    = bus.in_data;
  assign accept  = bus.in_valid & ready_q;
  assign baseCrc = bus.in_sof ? init_value : crc_q;
  assign nextCrc = aProd ^ bProd;

  c_mat_mult #(.rows(crc_width), .cols(crc_width), .matrix(A_MAT)) uMatA (
    .vec_i (baseCrc),
    .prod_o(aProd)
  );

  c_mat_mult #(.rows(crc_width), .cols(data_width), .matrix(B_MAT)) uMatB (
    .vec_i (dVec),
    .prod_o(bProd)
  );

  // A sof beat always restarts from init_value, so ACCUM needs no separate restart branch.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    out_d   = out_q;
    stray_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_sof) begin
            crc_d   = nextCrc;
            state_d = bus.in_eof ? DONE : ACCUM;
          end else begin
            stray_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          crc_d   = nextCrc;
          state_d = bus.in_eof ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.crc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) out_d = crc_d ^ final_xor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= init_value;
      out_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
      ready_q <= (state_d != DONE);
      valid_q <= (state_d == DONE);
      stray_q <= stray_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.crc_valid = valid_q;
  assign bus.crc_out   = out_q;
  assign stray_beat_o  = stray_q;
endmodule
